// File: rtl/sync_fifo_rf_if.sv
// Handshake and status bundle for sync_fifo_rf.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_rf_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 6
);
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [ADDR:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, dout_vld, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, dout_vld, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_rf.sv
// Single-clock FIFO on a flop-based register file.
// Pointers carry one extra wrap bit, so their difference is the occupancy.
// Every flag is registered from the next-state occupancy. The flags therefore
// change on the same edge as the level.
// FWFT selects either a registered read port or a look-ahead head word.
module sync_fifo_rf #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int ADDR      = 6,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 60,
  parameter int AEMPTY_TH = 4
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_rf_if.slave  bus
);

  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);
  localparam logic [ADDR:0] DEPTH_L  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] AFULL_L  = (ADDR+1)'(AFULL_TH);
  localparam logic [ADDR:0] AEMPTY_L = (ADDR+1)'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wr_ptr;
  logic [ADDR:0]    rd_ptr;
  logic [ADDR:0]    wr_next;
  logic [ADDR:0]    rd_next;
  logic [ADDR:0]    level_next;
  logic [ADDR-1:0]  wr_idx;
  logic [ADDR-1:0]  rd_idx;
  logic             full_q;
  logic             empty_q;
  logic             afull_q;
  logic             aempty_q;
  logic             ovf_q;
  logic             unf_q;
  logic             wr_ok;
  logic             rd_ok;

  // Accept decisions use only registered flags, so a read cannot make room
  // for a write in the same cycle. A write cannot feed a read in that cycle either.
  // A clear suppresses both transfers.
  assign wr_ok  = bus.wr_en & ~full_q  & ~bus.clr;
  assign rd_ok  = bus.rd_en & ~empty_q & ~bus.clr;
  assign wr_idx = wr_ptr[ADDR-1:0];
  assign rd_idx = rd_ptr[ADDR-1:0];

  // Next pointer values and the occupancy they imply.
  always_comb begin
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    if (wr_ok) wr_next = wr_ptr + ONE;
    if (rd_ok) rd_next = rd_ptr + ONE;
    level_next = wr_next - rd_next;
  end

  // Storage array: cleared only by reset; a clear leaves stored words intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= bus.din;
    end
  end

  // Pointers, status flags and the one-cycle error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      full_q   <= (level_next == DEPTH_L);
      empty_q  <= (level_next == '0);
      afull_q  <= (level_next >= AFULL_L);
      aempty_q <= (level_next <= AEMPTY_L);
      ovf_q    <= bus.wr_en & full_q;
      unf_q    <= bus.rd_en & empty_q;
    end
  end

  assign bus.level        = wr_ptr - rd_ptr;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is presented directly. It is forced to zero while empty,
      // so that reset and clear leave dout at zero.
      assign bus.dout     = empty_q ? '0 : mem[rd_idx];
      assign bus.dout_vld = ~empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             vld_q;

      // Registered read port: data lands one cycle after an accepted read and is held after that.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else if (bus.clr) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_idx];
        end
      end

      assign bus.dout     = dout_q;
      assign bus.dout_vld = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_rf.sv
// Directed bench for sync_fifo_rf.
// u0 is the standard-read instance and u1 is the first-word-fall-through instance.
module tb_sync_fifo_rf;
  localparam int WIDTH = 8;
  localparam int ADDR  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  sync_fifo_rf_if #(.WIDTH(WIDTH), .ADDR(ADDR)) f0 ();
  sync_fifo_rf_if #(.WIDTH(WIDTH), .ADDR(ADDR)) f1 ();

  sync_fifo_rf #(.WIDTH(WIDTH), .DEPTH(64), .ADDR(ADDR), .FWFT(0),
                 .AFULL_TH(60), .AEMPTY_TH(4))
    u0 (.clk(clk), .rst(rst), .bus(f0));

  sync_fifo_rf #(.WIDTH(WIDTH), .DEPTH(64), .ADDR(ADDR), .FWFT(1),
                 .AFULL_TH(60), .AEMPTY_TH(4))
    u1 (.clk(clk), .rst(rst), .bus(f1));

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] data, input logic c);
    f0.wr_en = wr;
    f0.rd_en = rd;
    f0.din   = data;
    f0.clr   = c;
    tick();
  endtask

  task automatic applyStimulusFwft(input logic wr, input logic rd, input logic [7:0] data);
    f1.wr_en = wr;
    f1.rd_en = rd;
    f1.din   = data;
    tick();
  endtask

  task automatic checkResetF0(input string pre);
    checkOutput({pre, "_level"},  f0.level,        32'd0);
    checkOutput({pre, "_empty"},  f0.empty,        32'd1);
    checkOutput({pre, "_full"},   f0.full,         32'd0);
    checkOutput({pre, "_afull"},  f0.almost_full,  32'd0);
    checkOutput({pre, "_aempty"}, f0.almost_empty, 32'd1);
    checkOutput({pre, "_dout"},   f0.dout,         32'd0);
    checkOutput({pre, "_vld"},    f0.dout_vld,     32'd0);
    checkOutput({pre, "_ovf"},    f0.overflow,     32'd0);
    checkOutput({pre, "_unf"},    f0.underflow,    32'd0);
  endtask

  initial begin
    f0.clr = 1'b0; f0.wr_en = 1'b0; f0.rd_en = 1'b0; f0.din = '0;
    f1.clr = 1'b0; f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.din = '0;

    #2 rst = 1'b1;
    #4;
    checkResetF0("rst");
    checkOutput("rst_fwft_vld",  f1.dout_vld, 32'd0);
    checkOutput("rst_fwft_dout", f1.dout,     32'd0);
    #6 rst = 1'b0;
    tick();
    $display("[TB] reset released");

    // FWFT: a written word is visible next cycle without any read request
    applyStimulusFwft(1'b1, 1'b0, 8'hA5);
    f1.wr_en = 1'b0;
    checkOutput("fwft_dout_a5", f1.dout,     32'hA5);
    checkOutput("fwft_vld",     f1.dout_vld, 32'd1);
    checkOutput("fwft_level1",  f1.level,    32'd1);
    applyStimulusFwft(1'b0, 1'b0, 8'h00);
    checkOutput("fwft_hold",    f1.dout,     32'hA5);
    applyStimulusFwft(1'b0, 1'b1, 8'h00);
    f1.rd_en = 1'b0;
    checkOutput("fwft_pop_empty", f1.empty,    32'd1);
    checkOutput("fwft_pop_vld",   f1.dout_vld, 32'd0);
    checkOutput("fwft_pop_level", f1.level,    32'd0);
    // write+read while empty: the read is rejected and the write lands
    applyStimulusFwft(1'b1, 1'b1, 8'h3C);
    checkOutput("fwft_unf",       f1.underflow, 32'd1);
    checkOutput("fwft_wr_level",  f1.level,     32'd1);
    checkOutput("fwft_wr_dout",   f1.dout,      32'h3C);
    applyStimulusFwft(1'b1, 1'b0, 8'hC3);
    checkOutput("fwft_unf_clr",   f1.underflow, 32'd0);
    checkOutput("fwft_head_kept", f1.dout,      32'h3C);
    checkOutput("fwft_level2",    f1.level,     32'd2);
    applyStimulusFwft(1'b0, 1'b1, 8'h00);
    checkOutput("fwft_next_head", f1.dout,      32'hC3);
    checkOutput("fwft_level_dec", f1.level,     32'd1);
    applyStimulusFwft(1'b0, 1'b1, 8'h00);
    f1.rd_en = 1'b0;
    checkOutput("fwft_drained",   f1.empty,     32'd1);

    // Fill with 0x01..0x40, checking the level and the threshold flags on every write
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
      checkOutput($sformatf("fill_level_%0d", i),  f0.level,        32'(i));
      checkOutput($sformatf("fill_afull_%0d", i),  f0.almost_full,  32'(i >= 60));
      checkOutput($sformatf("fill_aempty_%0d", i), f0.almost_empty, 32'(i <= 4));
      checkOutput($sformatf("fill_full_%0d", i),   f0.full,         32'(i == 64));
    end
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b0);
    checkOutput("ovf_pulse", f0.overflow, 32'd1);
    checkOutput("ovf_level", f0.level,    32'd64);
    checkOutput("ovf_full",  f0.full,     32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_end",   f0.overflow, 32'd0);

    // Drain: data arrives one cycle after each accepted read
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput($sformatf("rd_dout_%0d", i),  f0.dout,     32'(i));
      checkOutput($sformatf("rd_vld_%0d", i),   f0.dout_vld, 32'd1);
      checkOutput($sformatf("rd_level_%0d", i), f0.level,    32'(64 - i));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rd_vld_drop", f0.dout_vld, 32'd0);
    checkOutput("rd_hold",     f0.dout,     32'h40);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("unf_pulse", f0.underflow, 32'd1);
    checkOutput("unf_empty", f0.empty,     32'd1);
    checkOutput("unf_dout",  f0.dout,      32'h40);
    checkOutput("unf_vld",   f0.dout_vld,  32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("unf_end",   f0.underflow, 32'd0);

    // Steady state at level 32 with simultaneous reads and writes across the pointer wrap
    for (int j = 0; j < 32; j++) applyStimulus(1'b1, 1'b0, 8'(j), 1'b0);
    checkOutput("ss_level_start", f0.level, 32'd32);
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 1'b1, 8'(32 + k), 1'b0);
      checkOutput($sformatf("ss_dout_%0d", k),  f0.dout,  32'(k));
      checkOutput($sformatf("ss_level_%0d", k), f0.level, 32'd32);
    end

    // At full, a combined read and write accepts only the read
    for (int j = 0; j < 32; j++) applyStimulus(1'b1, 1'b0, 8'(132 + j), 1'b0);
    checkOutput("full_again", f0.full, 32'd1);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0);
    checkOutput("fullrw_dout",  f0.dout,     32'd100);
    checkOutput("fullrw_vld",   f0.dout_vld, 32'd1);
    checkOutput("fullrw_level", f0.level,    32'd63);
    checkOutput("fullrw_ovf",   f0.overflow, 32'd1);
    checkOutput("fullrw_full",  f0.full,     32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("fullrw_ovf_end", f0.overflow, 32'd0);

    // Synchronous clear, including a clear that overrides a write in the same cycle
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("clr_level", f0.level, 32'd0);
    for (int j = 0; j < 10; j++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + j), 1'b0);
    checkOutput("clr_pre_level",  f0.level,        32'd10);
    checkOutput("clr_pre_aempty", f0.almost_empty, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1);
    checkResetF0("clr");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("clr_no_write", f0.level, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("clr_ptr_dout", f0.dout,     32'h77);
    checkOutput("clr_ptr_vld",  f0.dout_vld, 32'd1);

    // Asynchronous reset in the middle of a burst, between clock edges
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
    checkOutput("burst_dout",  f0.dout,  32'h11);
    checkOutput("burst_level", f0.level, 32'd3);
    #3 rst = 1'b1;
    #1;
    checkResetF0("arst");
    f0.wr_en = 1'b0;
    f0.rd_en = 1'b0;
    #2 rst = 1'b0;
    tick();
    checkResetF0("arst_post");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
